cofre_sequencial: RTL

- Clocked, parametrised successor of the combinational safe comparator.
- Registers each attempt on a request pulse and compares it with the stored password.
- Reports open, near-miss (within TOL) and wrong status, plus the signed difference for the 7-segment display path.
- Counts failed attempts and enters a timed lockout after MAX_TENT consecutive failures.
- Sits between the switch inputs and the existing LED/display logic.

---
 rtl/cofre_sequencial_pkg.sv | 17 +
 rtl/cofre_sequencial_if.sv | 32 +++
 rtl/cofre_sequencial_subtrator_abs.sv | 17 +
 rtl/cofre_sequencial.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cofre_sequencial_pkg.sv
// Shared types and default constants for the sequential safe (cofre_sequencial).
package cofre_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        AVALIA    = 2'd1,
        ABERTO    = 2'd2,
        BLOQUEADO = 2'd3
    } estado_t;

    localparam int W_DEF             = 4;
    localparam int TOL_DEF           = 3;
    localparam int MAX_TENT_DEF      = 3;
    localparam int LOCK_CYCLES_DEF   = 8;
    localparam int ABERTO_CICLOS_DEF = 16;

endpackage

// File: rtl/cofre_sequencial_if.sv
// Switch-side/LED-side bundle of the sequential safe; master drives the switches.
interface cofre_sequencial_if
    import cofre_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int MAX_TENT = MAX_TENT_DEF
);
    localparam int TW = $clog2(MAX_TENT + 1);

    logic [W-1:0]  senha;
    logic [W-1:0]  tentativa;
    logic          tentar;
    logic          fechar;
    logic          aberto;
    logic          perto;
    logic          errada;
    logic          bloqueado;
    logic [W-1:0]  diff;
    logic          sinal;
    logic [TW-1:0] tent_rest;

    modport master (
        output senha, tentativa, tentar, fechar,
        input  aberto, perto, errada, bloqueado, diff, sinal, tent_rest
    );

    modport slave (
        input  senha, tentativa, tentar, fechar,
        output aberto, perto, errada, bloqueado, diff, sinal, tent_rest
    );

endinterface

// File: rtl/cofre_sequencial_subtrator_abs.sv
// Combinational |a - b| with borrow; borrow is 1 when b > a.
module subtrator_abs #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] magnitude,
    output logic         borrow
);

    logic [W-1:0] dif;

    assign {borrow, dif} = {1'b0, a} - {1'b0, b};
    // Negating the wrapped difference yields b - a, which always fits in W bits.
    assign magnitude = borrow ? (~dif + W'(1)) : dif;

endmodule

// File: rtl/cofre_sequencial.sv
// Sequential safe: registered attempt evaluation, near-miss status and timed lockout.
// Optional macro AUTO_FECHA_EN adds an auto-close timer of ABERTO_CICLOS cycles in ABERTO.
module cofre_sequencial
    import cofre_pkg::*;
#(
    parameter int W             = W_DEF,
    parameter int TOL           = TOL_DEF,
    parameter int MAX_TENT      = MAX_TENT_DEF,
    parameter int LOCK_CYCLES   = LOCK_CYCLES_DEF,
    parameter int ABERTO_CICLOS = ABERTO_CICLOS_DEF
) (
    input logic               clk,
    input logic               rst,
    cofre_sequencial_if.slave bus
);

    localparam int TW = $clog2(MAX_TENT + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [TW-1:0] TENT_MAX = TW'(MAX_TENT);
    localparam logic [LW-1:0] LOCK_LD  = LW'(LOCK_CYCLES);

    if (W < 2 || W > 16 || TOL < 0 || TOL >= (2 ** W) || MAX_TENT < 1 ||
        LOCK_CYCLES < 1 || ABERTO_CICLOS < 1) begin : g_param_err
        $error("cofre_sequencial: illegal parameter set");
    end

    estado_t       state;
    logic [W-1:0]  tent_reg;
    logic [LW-1:0] lock_timer;

    logic          aberto_q;
    logic          perto_q;
    logic          errada_q;
    logic          bloqueado_q;
    logic [W-1:0]  diff_q;
    logic          sinal_q;
    logic [TW-1:0] tent_rest_q;

    logic [W-1:0]  mag;
    logic          borrow;
    logic          iguais;
    logic          dentro_tol;
    logic          fecha_req;

    subtrator_abs #(.W(W)) u_sub (
        .a         (bus.senha),
        .b         (tent_reg),
        .magnitude (mag),
        .borrow    (borrow)
    );

    assign iguais     = (mag == '0);
    assign dentro_tol = (int'(mag) <= TOL);

`ifdef AUTO_FECHA_EN
    localparam int AW = $clog2(ABERTO_CICLOS + 1);
    localparam logic [AW-1:0] AUTO_LD = AW'(ABERTO_CICLOS);
    logic [AW-1:0] auto_cnt;

    // Expiry is treated exactly like a user close request.
    assign fecha_req = bus.fechar || (auto_cnt == AW'(1));
`else
    assign fecha_req = bus.fechar;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= OCIOSO;
            tent_reg    <= '0;
            lock_timer  <= '0;
            aberto_q    <= 1'b0;
            perto_q     <= 1'b0;
            errada_q    <= 1'b0;
            bloqueado_q <= 1'b0;
            diff_q      <= '0;
            sinal_q     <= 1'b0;
            tent_rest_q <= TENT_MAX;
`ifdef AUTO_FECHA_EN
            auto_cnt    <= '0;
`endif
        end else begin
            case (state)
                OCIOSO: begin
                    if (bus.tentar) begin
                        tent_reg <= bus.tentativa;
                        state    <= AVALIA;
                    end
                end

                AVALIA: begin
                    diff_q  <= mag;
                    sinal_q <= borrow;
                    if (iguais) begin
                        aberto_q    <= 1'b1;
                        errada_q    <= 1'b0;
                        perto_q     <= 1'b0;
                        tent_rest_q <= TENT_MAX;
                        state       <= ABERTO;
`ifdef AUTO_FECHA_EN
                        auto_cnt    <= AUTO_LD;
`endif
                    end else begin
                        errada_q    <= 1'b1;
                        perto_q     <= dentro_tol;
                        tent_rest_q <= tent_rest_q - TW'(1);
                        if (tent_rest_q == TW'(1)) begin
                            bloqueado_q <= 1'b1;
                            lock_timer  <= LOCK_LD;
                            state       <= BLOQUEADO;
                        end else begin
                            state <= OCIOSO;
                        end
                    end
                end

                ABERTO: begin
                    if (fecha_req) begin
                        aberto_q <= 1'b0;
                        diff_q   <= '0;
                        sinal_q  <= 1'b0;
                        perto_q  <= 1'b0;
                        errada_q <= 1'b0;
                        state    <= OCIOSO;
`ifdef AUTO_FECHA_EN
                        auto_cnt <= '0;
                    end else begin
                        auto_cnt <= auto_cnt - AW'(1);
`endif
                    end
                end

                BLOQUEADO: begin
                    // Timer value 1 marks the last lockout cycle.
                    if (lock_timer == LW'(1)) begin
                        bloqueado_q <= 1'b0;
                        tent_rest_q <= TENT_MAX;
                        lock_timer  <= '0;
                        state       <= OCIOSO;
                    end else begin
                        lock_timer <= lock_timer - LW'(1);
                    end
                end

                default: state <= OCIOSO;
            endcase
        end
    end

    assign bus.aberto    = aberto_q;
    assign bus.perto     = perto_q;
    assign bus.errada    = errada_q;
    assign bus.bloqueado = bloqueado_q;
    assign bus.diff      = diff_q;
    assign bus.sinal     = sinal_q;
    assign bus.tent_rest = tent_rest_q;

endmodule
